// File: rtl/jedro_1_arb_pkg.sv
// Shared types and constants for the jedro_1 unified-memory arbiter.
package jedro_1_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_e;

    localparam int DEFAULT_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/jedro_1_arb_starve_ctr.sv
// Saturating count of back-to-back data grants taken while fetch was waiting,
// flagging when fetch must be let through.
module jedro_1_arb_starve_ctr #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic instr_req_i,
    input  logic instr_gnt_i,
    input  logic data_gnt_i,
    output logic limit_o
);

    localparam int CW = $clog2(MAX_STREAK + 1);

    logic [CW-1:0] streak_d;
    logic [CW-1:0] streak_q;

    assign limit_o = (streak_q == CW'(MAX_STREAK));

    always_comb begin
        streak_d = streak_q;
        if (!instr_req_i || instr_gnt_i) begin
            streak_d = '0;
        end else if (data_gnt_i && !limit_o) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port RAM between jedro_1 fetch and load/store, data first.
// Define JEDRO_1_ARB_STARVE_EN to bound how long fetch can be starved by data.
module jedro_1_mem_arbiter
    import jedro_1_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    owner_e owner_d, owner_q;
    logic   store_d, store_q;
    logic   instr_gnt, data_gnt;
    logic   starve_limit;

`ifdef JEDRO_1_ARB_STARVE_EN
    jedro_1_arb_starve_ctr #(
        .MAX_STREAK (MAX_DATA_STREAK)
    ) u_starve_ctr (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .instr_req_i (instr_req_i),
        .instr_gnt_i (instr_gnt),
        .data_gnt_i  (data_gnt),
        .limit_o     (starve_limit)
    );
`else
    logic unused_streak_cfg;
    assign unused_streak_cfg = (MAX_DATA_STREAK != 0);
    assign starve_limit      = 1'b0;
`endif

    // No grants while reset is held, so every output reads 0 during reset.
    always_comb begin
        data_gnt  = rstn_i && data_req_i && !(starve_limit && instr_req_i);
        instr_gnt = rstn_i && instr_req_i && !data_gnt;

        owner_d = OWNER_NONE;
        store_d = 1'b0;
        if (instr_gnt) begin
            owner_d = OWNER_INSTR;
        end else if (data_gnt) begin
            owner_d = OWNER_DATA;
            store_d = data_we_i;
        end

        instr_gnt_o = instr_gnt;
        data_gnt_o  = data_gnt;
        mem_en_o    = instr_gnt || data_gnt;
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        if (data_gnt) begin
            mem_addr_o = data_addr_i;
            if (data_we_i) begin
                mem_we_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end
        end else if (instr_gnt) begin
            mem_addr_o = instr_addr_i;
        end

        instr_rvalid_o = (owner_q == OWNER_INSTR);
        data_rvalid_o  = (owner_q == OWNER_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
        data_rdata_o   = (data_rvalid_o && !store_q) ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q <= OWNER_NONE;
            store_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
        end
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Scoreboard bench for jedro_1_mem_arbiter: a reference memory plus an
// arbitration rule model predict grants and responses for random traffic.
module tb_jedro_1_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int BW         = DW / 8;
    localparam int MAX_STREAK = 4;
    localparam int WORDS      = 64;
`ifdef JEDRO_1_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          instr_req = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic          instr_gnt, instr_rvalid;
    logic [DW-1:0] instr_rdata;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [BW-1:0] data_be = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_gnt, data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_DATA_STREAK (MAX_STREAK)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          iq[$];
    exp_t          dq[$];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] ram [WORDS];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            streak = 0;
    int            instr_gnts = 0;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 0) return 32'h0010_0093;
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0F13);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: read data appears the cycle after mem_en.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < WORDS; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                for (int b = 0; b < BW; b++)
                    if (mem_we[b]) ram[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                mem_rdata <= ram[mem_addr[7:2]];
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_instr_gnt"}, instr_gnt, 0);
        check_output({tag, "_instr_rvalid"}, instr_rvalid, 0);
        check_output({tag, "_instr_rdata"}, instr_rdata, 0);
        check_output({tag, "_data_gnt"}, data_gnt, 0);
        check_output({tag, "_data_rvalid"}, data_rvalid, 0);
        check_output({tag, "_data_rdata"}, data_rdata, 0);
        check_output({tag, "_mem_en"}, mem_en, 0);
        check_output({tag, "_mem_we"}, mem_we, 0);
        check_output({tag, "_mem_addr"}, mem_addr, 0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Monitor: every response must land exactly on its due cycle with the right data.
    initial begin : monitor
        logic due_i, due_d;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                due_i = (iq.size() > 0) && (iq[0].due == cyc);
                due_d = (dq.size() > 0) && (dq[0].due == cyc);
                check_output("instr_rvalid", instr_rvalid, due_i);
                if (due_i) begin
                    e = iq.pop_front();
                    check_output("instr_rdata", instr_rdata, e.data);
                end else begin
                    check_output("instr_rdata_idle", instr_rdata, 0);
                end
                check_output("data_rvalid", data_rvalid, due_d);
                if (due_d) begin
                    e = dq.pop_front();
                    check_output("data_rdata", data_rdata, e.data);
                end else begin
                    check_output("data_rdata_idle", data_rdata, 0);
                end
            end
        end
    end

    task automatic apply_stimulus();
        if (!instr_req && $urandom_range(0, 99) < 60) begin
            instr_req  = 1'b1;
            instr_addr = {24'h0, 6'($urandom), 2'b00};
        end
        if (!data_req && $urandom_range(0, 99) < 55) begin
            data_req   = 1'b1;
            data_we    = 1'($urandom_range(0, 1));
            data_be    = 4'($urandom_range(1, 15));
            data_addr  = {24'h0, 6'($urandom), 2'b00};
            data_wdata = $urandom;
        end
    endtask

    // One cycle: predict the winner, check the grant side, push the expected response.
    task automatic step(input bit gen_new);
        int   win;
        int   idx;
        logic [DW-1:0] w;
        @(negedge clk);
        if (STARVE_EN && data_req && instr_req && streak == MAX_STREAK) win = 1;
        else if (data_req) win = 2;
        else if (instr_req) win = 1;
        else win = 0;
        if (!instr_req || win == 1) streak = 0;
        else if (win == 2 && streak < MAX_STREAK) streak++;

        check_output("instr_gnt", instr_gnt, (win == 1));
        check_output("data_gnt", data_gnt, (win == 2));
        check_output("mem_en", mem_en, (win != 0));
        if (win == 1) begin
            check_output("mem_addr_instr", mem_addr, instr_addr);
            check_output("mem_we_instr", mem_we, 0);
            idx = int'(instr_addr[7:2]);
            iq.push_back('{data: ref_mem[idx], due: cyc + 1});
            instr_gnts++;
        end else if (win == 2) begin
            idx = int'(data_addr[7:2]);
            check_output("mem_addr_data", mem_addr, data_addr);
            check_output("mem_we_data", mem_we, data_we ? data_be : 4'h0);
            if (data_we) begin
                check_output("mem_wdata", mem_wdata, data_wdata);
                w = ref_mem[idx];
                for (int b = 0; b < BW; b++)
                    if (data_be[b]) w[b*8 +: 8] = data_wdata[b*8 +: 8];
                ref_mem[idx] = w;
                dq.push_back('{data: '0, due: cyc + 1});
            end else begin
                dq.push_back('{data: ref_mem[idx], due: cyc + 1});
            end
        end
        @(posedge clk);
        #1;
        if (win == 1) instr_req = 1'b0;
        if (win == 2) data_req = 1'b0;
        if (gen_new) apply_stimulus();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);

        // Reset held for three cycles, then released with no traffic.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_all_zero("rst_release");
        @(posedge clk);
        #1;

        // Fetch only from address 0.
        instr_req  = 1'b1;
        instr_addr = 32'h0;
        step(0);
        step(0);

        // Store then load the same word.
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'hF;
        data_addr  = 32'h40;
        data_wdata = 32'hDEAD_BEEF;
        step(0);
        data_req   = 1'b1;
        data_we    = 1'b0;
        step(0);
        step(0);

        // Contention: both sides request every cycle for ten cycles.
        instr_gnts = 0;
        for (int i = 0; i < 10; i++) begin
            if (!instr_req) begin
                instr_req  = 1'b1;
                instr_addr = {24'h0, 6'($urandom), 2'b00};
            end
            data_req   = 1'b1;
            data_we    = 1'($urandom_range(0, 1));
            data_be    = 4'($urandom_range(1, 15));
            data_addr  = {24'h0, 6'($urandom), 2'b00};
            data_wdata = $urandom;
            step(0);
        end
        check_output("contention_instr_gnts", instr_gnts, STARVE_EN ? 2 : 0);
        step(0);

        // Reset in the cycle after a data grant drops the pending response.
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h80;
        step(0);
        rstn      = 1'b0;
        instr_req = 1'b0;
        data_req  = 1'b0;
        iq.delete();
        dq.delete();
        streak = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("rst_mid_no_rvalid", data_rvalid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic, then drain.
        repeat (400) step(1);
        repeat (4) step(0);
        check_output("drain_empty", iq.size() + dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
